// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory line port between icache refills and dcache refill/write-back.
// Round-robin between the two caches, with a watchdog that completes stalled accesses with an error.
module cache_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  input  logic              dc_req_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic              dc_we_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              ic_ack_o,
  output logic [LINE_W-1:0] ic_rdata_o,
  output logic              ic_err_o,
  output logic              dc_ack_o,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              dc_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              busy_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic              owner_dc_q;
  logic              last_dc_q;
  logic [WD_W-1:0]   wdog_q;

  logic              pick_dc_d;
  logic              wd_expired_d;
  logic              fin_err_d;
  logic [LINE_W-1:0] fin_rdata_d;

  // Arbitration choice and completion values for the current cycle.
  always_comb begin
    pick_dc_d = 1'b0;
    if (ic_req_i && dc_req_i) begin
      pick_dc_d = !last_dc_q;
    end else if (dc_req_i) begin
      pick_dc_d = 1'b1;
    end else begin
      pick_dc_d = 1'b0;
    end
    wd_expired_d = (wdog_q == WD_W'(TIMEOUT - 1));
    fin_err_d    = !mem_ack_i;
    if (mem_ack_i && !mem_we_o) begin
      fin_rdata_d = mem_rdata_i;
    end else begin
      fin_rdata_d = {LINE_W{1'b0}};
    end
  end

  // Transaction sequencer; all outputs registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      owner_dc_q  <= 1'b0;
      last_dc_q   <= 1'b0;
      wdog_q      <= {WD_W{1'b0}};
      ic_ack_o    <= 1'b0;
      ic_rdata_o  <= {LINE_W{1'b0}};
      ic_err_o    <= 1'b0;
      dc_ack_o    <= 1'b0;
      dc_rdata_o  <= {LINE_W{1'b0}};
      dc_err_o    <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= {ADDR_W{1'b0}};
      mem_wdata_o <= {LINE_W{1'b0}};
      grant_o     <= 2'b00;
      busy_o      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ic_req_i || dc_req_i) begin
            owner_dc_q  <= pick_dc_d;
            mem_req_o   <= 1'b1;
            mem_we_o    <= pick_dc_d && dc_we_i;
            mem_addr_o  <= pick_dc_d ? dc_addr_i : ic_addr_i;
            mem_wdata_o <= (pick_dc_d && dc_we_i) ? dc_wdata_i : {LINE_W{1'b0}};
            grant_o     <= pick_dc_d ? 2'b10 : 2'b01;
            busy_o      <= 1'b1;
            wdog_q      <= {WD_W{1'b0}};
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A memory ack on the last watchdog cycle still wins over the timeout.
          if (mem_ack_i || wd_expired_d) begin
            mem_req_o <= 1'b0;
            state_q   <= ST_DONE;
            if (owner_dc_q) begin
              dc_ack_o   <= 1'b1;
              dc_rdata_o <= fin_rdata_d;
              dc_err_o   <= fin_err_d;
            end else begin
              ic_ack_o   <= 1'b1;
              ic_rdata_o <= fin_rdata_d;
              ic_err_o   <= fin_err_d;
            end
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        ST_DONE: begin
          ic_ack_o  <= 1'b0;
          dc_ack_o  <= 1'b0;
          last_dc_q <= owner_dc_q;
          grant_o   <= 2'b00;
          busy_o    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: refills, ties, alternation, write-back,
// watchdog timeout and mid-transaction reset.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int TO = 64;

  localparam logic [5:0] S_IDLE   = 6'b0_0_00_0_0;
  localparam logic [5:0] S_IC_BSY = 6'b1_1_01_0_0;
  localparam logic [5:0] S_IC_ACK = 6'b0_1_01_1_0;
  localparam logic [5:0] S_DC_BSY = 6'b1_1_10_0_0;
  localparam logic [5:0] S_DC_ACK = 6'b0_1_10_0_1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ic_req, dc_req, dc_we, mem_ack;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] dc_wdata, mem_rdata;
  logic          ic_ack, dc_ack, ic_err, dc_err, mem_req, mem_we, busy;
  logic [LW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    grant;
  logic [5:0]    st;
  logic [5:0]    e_bsy, e_ack;
  logic          exp_dc;

  int n_assert = 0;
  int n_fail   = 0;

  // status vector: {mem_req, busy, grant[1:0], ic_ack, dc_ack}
  assign st = {mem_req, busy, grant, ic_ack, dc_ack};

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ic_req_i(ic_req), .ic_addr_i(ic_addr),
    .dc_req_i(dc_req), .dc_addr_i(dc_addr), .dc_we_i(dc_we), .dc_wdata_i(dc_wdata),
    .ic_ack_o(ic_ack), .ic_rdata_o(ic_rdata), .ic_err_o(ic_err),
    .dc_ack_o(dc_ack), .dc_rdata_o(dc_rdata), .dc_err_o(dc_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .grant_o(grant), .busy_o(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ack = 1'b0;
    ic_addr = 32'h0; dc_addr = 32'h0; dc_wdata = 128'h0; mem_rdata = 128'h0;
    step(); step();
    check("reset_status", 128'(st), 128'(S_IDLE));
    check("reset_misc", 128'({mem_we, ic_err, dc_err}), 128'(3'b000));
    check("reset_addr", 128'(mem_addr), 128'h0);
    rst_n = 1'b1;
    step();
    check("idle_no_req", 128'(st), 128'(S_IDLE));

    // single icache refill, ack 4 cycles into the transfer
    ic_addr = 32'h0000_0040; ic_req = 1'b1;
    step();
    check("t1_grant", 128'(st), 128'(S_IC_BSY));
    check("t1_addr", 128'(mem_addr), 128'h40);
    check("t1_we", 128'(mem_we), 128'h0);
    for (int k = 0; k < 3; k++) step();
    check("t1_wait", 128'(st), 128'(S_IC_BSY));
    mem_rdata = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF; mem_ack = 1'b1;
    step();
    check("t1_ack", 128'(st), 128'(S_IC_ACK));
    check("t1_rdata", ic_rdata, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    check("t1_err", 128'(ic_err), 128'h0);
    mem_ack = 1'b0; mem_rdata = 128'h0;
    step();
    check("t1_done", 128'(st), 128'(S_IDLE));
    ic_req = 1'b0;
    step();
    check("t1_no_regrant", 128'(st), 128'(S_IDLE));
    check("t1_rdata_hold", ic_rdata, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);

    // tie right after reset goes to dcache, icache follows after turnaround
    rst_n = 1'b0; step(); rst_n = 1'b1;
    ic_req = 1'b1; dc_req = 1'b1; dc_addr = 32'h0000_0080;
    step();
    check("t2_dc_first", 128'(st), 128'(S_DC_BSY));
    check("t2_dc_addr", 128'(mem_addr), 128'h80);
    mem_ack = 1'b1; mem_rdata = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    step();
    check("t2_dc_ack", 128'(st), 128'(S_DC_ACK));
    check("t2_dc_rdata", dc_rdata, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5);
    mem_ack = 1'b0;
    step();
    check("t2_gap", 128'(st), 128'(S_IDLE));
    dc_req = 1'b0;
    step();
    check("t2_ic_next", 128'(st), 128'(S_IC_BSY));
    check("t2_ic_addr", 128'(mem_addr), 128'h40);
    mem_ack = 1'b1; mem_rdata = 128'h0B0B0B0B_0B0B0B0B_0B0B0B0B_0B0B0B0B;
    step();
    check("t2_ic_ack", 128'(st), 128'(S_IC_ACK));
    check("t2_ic_rdata", ic_rdata, 128'h0B0B0B0B_0B0B0B0B_0B0B0B0B_0B0B0B0B);
    mem_ack = 1'b0;
    step();
    ic_req = 1'b0;
    step();
    check("t2_idle", 128'(st), 128'(S_IDLE));

    // both requests held: grants alternate D,I,D,I,D,I
    ic_req = 1'b1; dc_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_dc = (i % 2 == 0);
      e_bsy  = exp_dc ? S_DC_BSY : S_IC_BSY;
      e_ack  = exp_dc ? S_DC_ACK : S_IC_ACK;
      step();
      check("t3_grant", 128'(st), 128'(e_bsy));
      mem_ack = 1'b1; mem_rdata = {4{32'hC0DE_0000 + 32'(i)}};
      step();
      check("t3_ack", 128'(st), 128'(e_ack));
      check("t3_rdata", exp_dc ? dc_rdata : ic_rdata, {4{32'hC0DE_0000 + 32'(i)}});
      mem_ack = 1'b0;
      step();
      check("t3_done", 128'(st), 128'(S_IDLE));
    end
    ic_req = 1'b0; dc_req = 1'b0;
    step();
    check("t3_idle", 128'(st), 128'(S_IDLE));

    // dcache write-back
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_0100;
    dc_wdata = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    step();
    check("t4_grant", 128'(st), 128'(S_DC_BSY));
    check("t4_we", 128'(mem_we), 128'h1);
    check("t4_wdata", mem_wdata, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
    mem_ack = 1'b1; mem_rdata = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    step();
    check("t4_ack", 128'(st), 128'(S_DC_ACK));
    check("t4_rdata_zero", dc_rdata, 128'h0);
    check("t4_err", 128'(dc_err), 128'h0);
    mem_ack = 1'b0;
    step();
    dc_req = 1'b0; dc_we = 1'b0;
    step();
    check("t4_idle", 128'(st), 128'(S_IDLE));

    // memory never answers: timeout after TO busy cycles
    ic_req = 1'b1; ic_addr = 32'h0000_0200;
    step();
    check("t5_grant", 128'(st), 128'(S_IC_BSY));
    for (int k = 0; k < TO - 1; k++) step();
    check("t5_still_busy", 128'(st), 128'(S_IC_BSY));
    step();
    check("t5_to_ack", 128'(st), 128'(S_IC_ACK));
    check("t5_to_err", 128'(ic_err), 128'h1);
    check("t5_to_rdata", ic_rdata, 128'h0);
    step();
    ic_req = 1'b0;
    step();
    check("t5_idle", 128'(st), 128'(S_IDLE));
    ic_req = 1'b1;
    step();
    check("t5_next_grant", 128'(st), 128'(S_IC_BSY));
    mem_ack = 1'b1; mem_rdata = 128'h0C0C0C0C_0C0C0C0C_0C0C0C0C_0C0C0C0C;
    step();
    check("t5_next_ack", 128'(st), 128'(S_IC_ACK));
    check("t5_next_err", 128'(ic_err), 128'h0);
    check("t5_next_rdata", ic_rdata, 128'h0C0C0C0C_0C0C0C0C_0C0C0C0C_0C0C0C0C);
    mem_ack = 1'b0;
    step();
    ic_req = 1'b0;
    step();

    // ack on the last watchdog cycle beats the timeout
    dc_req = 1'b1;
    step();
    check("t5b_grant", 128'(st), 128'(S_DC_BSY));
    for (int k = 0; k < TO - 1; k++) step();
    mem_ack = 1'b1; mem_rdata = 128'hD00DD00D_D00DD00D_D00DD00D_D00DD00D;
    step();
    check("t5b_ack", 128'(st), 128'(S_DC_ACK));
    check("t5b_err", 128'(dc_err), 128'h0);
    check("t5b_rdata", dc_rdata, 128'hD00DD00D_D00DD00D_D00DD00D_D00DD00D);
    mem_ack = 1'b0;
    step();
    dc_req = 1'b0;
    step();

    // reset during BUSY drops the transaction
    ic_req = 1'b1; dc_req = 1'b1;
    step();
    check("t6_ic_tie", 128'(st), 128'(S_IC_BSY));
    step(); step();
    rst_n = 1'b0;
    #1;
    check("t6_async_status", 128'(st), 128'(S_IDLE));
    check("t6_async_misc", 128'({mem_we, ic_err, dc_err}), 128'(3'b000));
    check("t6_async_ic_rdata", ic_rdata, 128'h0);
    check("t6_async_dc_rdata", dc_rdata, 128'h0);
    check("t6_async_addr", 128'(mem_addr), 128'h0);
    step();
    check("t6_no_ack", 128'(st), 128'(S_IDLE));
    rst_n = 1'b1;
    step();
    check("t6_dc_after_reset", 128'(st), 128'(S_DC_BSY));
    mem_ack = 1'b1; mem_rdata = 128'h0;
    step();
    check("t6_dc_ack", 128'(st), 128'(S_DC_ACK));
    mem_ack = 1'b0; ic_req = 1'b0; dc_req = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
